// File: rtl/pilha_responder.sv
// pilha_responder: handshaked operand-stack responder (push/pop/peek/clear); optional high-water mark via PILHA_HWM_EN
module pilha_responder #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             err_sticky,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [CW-1:0]    hwm
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] OP_PUSH = 2'b00, OP_POP = 2'b01, OP_PEEK = 2'b10, OP_CLR = 2'b11;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d, rsp_data_q, rsp_data_d;
  logic [CW-1:0] count_q, count_d;
  logic rsp_err_q, rsp_err_d, err_sticky_q, err_sticky_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic exec, is_read, push_ok, pop_ok, err, we;
  logic [AW-1:0] top;
  assign exec = state_q == EXEC;
  assign full = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
  assign is_read = op_q == OP_POP || op_q == OP_PEEK;
  assign push_ok = op_q == OP_PUSH && !full;
  assign pop_ok = is_read && !empty;
  assign err = (op_q == OP_PUSH && full) || (is_read && empty);
  assign top = AW'(count_q - CW'(1));
  assign req_ready = state_q == IDLE;
  assign rsp_valid = state_q == RESP;
  assign rsp_data = rsp_data_q;
  assign rsp_err = rsp_err_q;
  assign err_sticky = err_sticky_q;
  assign count = count_q;
  assign we = exec && push_ok;
  // next state: latch command in IDLE, execute it for one cycle, hold response until taken
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    data_d = data_q;
    count_d = count_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d = rsp_err_q;
    err_sticky_d = err_sticky_q;
    case (state_q)
      IDLE: if (req_valid) begin
        op_d = req_op;
        data_d = req_data;
        state_d = EXEC;
      end
      EXEC: begin
        state_d = RESP;
        count_d = op_q == OP_CLR ? '0 : push_ok ? count_q + CW'(1) : (op_q == OP_POP && pop_ok) ? count_q - CW'(1) : count_q;
        rsp_data_d = push_ok ? data_q : pop_ok ? mem[top] : '0;
        rsp_err_d = err;
        err_sticky_d = op_q == OP_CLR ? 1'b0 : err_sticky_q | err;
      end
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  // control and response registers; reset abandons any in-flight command
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q <= OP_PUSH;
      data_q <= '0;
      count_q <= '0;
      rsp_data_q <= '0;
      rsp_err_q <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      data_q <= data_d;
      count_q <= count_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q <= rsp_err_d;
      err_sticky_q <= err_sticky_d;
    end
  end
  // stack storage, deliberately left uninitialised by reset
  always_ff @(posedge clock) begin
    if (we) mem[AW'(count_q)] <= data_q;
  end
`ifdef PILHA_HWM_EN
  logic [CW-1:0] hwm_q, hwm_d;
  assign hwm = hwm_q;
  // track the deepest occupancy reached since reset or CLEAR
  always_comb begin
    hwm_d = hwm_q;
    if (exec && op_q == OP_CLR) hwm_d = '0;
    else if (we && count_d > hwm_q) hwm_d = count_d;
  end
  // high-water mark register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) hwm_q <= '0;
    else hwm_q <= hwm_d;
  end
`else
  assign hwm = '0;
`endif
endmodule

// File: tb/tb_pilha_responder.sv
// tb_pilha_responder: scoreboard bench for pilha_responder with directed command vectors
module tb_pilha_responder;
  localparam logic [1:0] PUSH = 2'b00, POP = 2'b01, PEEK = 2'b10, CLR = 2'b11;
  logic clock = 0, reset = 1;
  logic req_valid = 0, req_ready, rsp_valid, rsp_ready = 1, rsp_err, err_sticky, full, empty;
  logic [1:0] req_op = 0;
  logic [15:0] req_data = 0, rsp_data;
  logic [4:0] count, hwm;
  typedef struct packed {logic [15:0] d; logic e; logic [4:0] c; logic s;} exp_t;
  exp_t sb[$];
  int passed = 0, total = 0;
`ifdef PILHA_HWM_EN
  localparam logic [4:0] HWM_PEAK = 5'd5;
`else
  localparam logic [4:0] HWM_PEAK = 5'd0;
`endif

  pilha_responder dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_data(req_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .err_sticky(err_sticky), .full(full), .empty(empty), .count(count), .hwm(hwm)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // monitor: every accepted response is compared with the oldest expectation
  always @(negedge clock) begin
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) chk("unexpected_rsp", 1, 0);
      else begin
        exp_t x;
        x = sb.pop_front();
        chk("rsp_data", rsp_data, x.d);
        chk("rsp_err", rsp_err, x.e);
        chk("count", count, x.c);
        chk("err_sticky", err_sticky, x.s);
        chk("full", full, x.c == 5'd16);
        chk("empty", empty, x.c == 5'd0);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 50) begin @(negedge clock); n++; end
    if (!req_ready) chk("req_ready_timeout", 0, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin @(negedge clock); n++; end
    if (sb.size() != 0) chk("rsp_timeout", sb.size(), 0);
  endtask

  task automatic cmd(input logic [1:0] op, input logic [15:0] d, input logic [15:0] ed, input logic ee,
                     input logic [4:0] ec, input logic es);
    sb.push_back('{ed, ee, ec, es});
    req_op = op;
    req_data = d;
    req_valid = 1;
    wait_ready();
    @(posedge clock);
    #1 req_valid = 0;
    req_data = 16'h5a5a;
    req_op = ~op;
    chk("lat_exec", rsp_valid, 0);
    @(posedge clock);
    #1 chk("lat_resp", rsp_valid, 1);
    drain();
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_sticky", err_sticky, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_hwm", hwm, 0);
    reset = 0;
    @(negedge clock);
    chk("rst_req_ready", req_ready, 1);
    cmd(PUSH, 16'h1234, 16'h1234, 0, 1, 0);
    cmd(POP, 0, 16'h1234, 0, 0, 0);
    for (int i = 1; i <= 16; i++) cmd(PUSH, 16'(i), 16'(i), 0, 5'(i), 0);
    cmd(PUSH, 16'hbeef, 16'h0000, 1, 16, 1);
    cmd(PEEK, 0, 16'h0010, 0, 16, 1);
    for (int k = 0; k < 16; k++) cmd(POP, 0, 16'(16 - k), 0, 5'(15 - k), 1);
    cmd(POP, 0, 16'h0000, 1, 0, 1);
    cmd(PEEK, 0, 16'h0000, 1, 0, 1);
    cmd(CLR, 16'hffff, 16'h0000, 0, 0, 0);
    cmd(PUSH, 16'ha5a5, 16'ha5a5, 0, 1, 0);
    // stall: PEEK held in RESP with req_valid kept high carrying a POP
    rsp_ready = 0;
    sb.push_back('{16'ha5a5, 1'b0, 5'd1, 1'b0});
    req_op = PEEK;
    req_valid = 1;
    wait_ready();
    @(posedge clock);
    #1 req_op = POP;
    repeat (2) @(posedge clock);
    repeat (5) begin
      @(negedge clock);
      chk("stall_valid", rsp_valid, 1);
      chk("stall_data", rsp_data, 16'ha5a5);
      chk("stall_req_ready", req_ready, 0);
    end
    sb.push_back('{16'ha5a5, 1'b0, 5'd0, 1'b0});
    @(posedge clock);
    #1 rsp_ready = 1;
    @(posedge clock);
    @(negedge clock);
    chk("idle_after_rsp", req_ready, 1);
    @(posedge clock);
    #1 req_valid = 0;
    chk("second_accept", req_ready, 0);
    drain();
    // high-water mark sequence
    cmd(CLR, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cmd(PUSH, 16'(i + 100), 16'(i + 100), 0, 5'(i + 1), 0);
    cmd(POP, 0, 16'd104, 0, 4, 0);
    cmd(POP, 0, 16'd103, 0, 3, 0);
    cmd(PUSH, 16'd200, 16'd200, 0, 4, 0);
    chk("hwm_peak", hwm, HWM_PEAK);
    cmd(CLR, 0, 0, 0, 0, 0);
    chk("hwm_clear", hwm, 0);
    for (int i = 0; i < 3; i++) cmd(PUSH, 16'(i + 7), 16'(i + 7), 0, 5'(i + 1), 0);
    // reset while a PEEK response is pending
    rsp_ready = 0;
    req_op = PEEK;
    req_valid = 1;
    wait_ready();
    @(posedge clock);
    #1 req_valid = 0;
    repeat (2) @(negedge clock);
    chk("pre_rst_valid", rsp_valid, 1);
    chk("pre_rst_count", count, 3);
    reset = 1;
    #1 chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_count", count, 0);
    @(negedge clock);
    reset = 0;
    rsp_ready = 1;
    @(negedge clock);
    chk("post_rst_ready", req_ready, 1);
    chk("post_rst_empty", empty, 1);
    chk("post_rst_valid", rsp_valid, 0);
    chk("post_rst_hwm", hwm, 0);
    cmd(PUSH, 16'h00aa, 16'h00aa, 0, 1, 0);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
